vga_fb_scan: RTL
================

Name: vga_fb_scan

Overview:
Framebuffer scan-out stage that sits directly downstream of the VGA timing generator. It consumes the generator's x, y, blank, HS and VS outputs, fetches pixel colour from an internal 80x60-cell, 8-bit framebuffer (each cell 8x8 screen pixels), and drives sync-aligned RGB332 to the pins. A host-side write port with a valid/ready handshake loads cells, and a hardware clear engine fills the whole buffer.

Parameters:
COLS, 80, cells per row
ROWS, 60, cell rows
CELL_SHIFT, 3, log2 of cell size in pixels (8x8)
CLR_COLOR, 8'h00, fill value used by the clear engine
ADDR_W, 13, framebuffer address width (must satisfy 2^ADDR_W >= COLS*ROWS)

Ports:
CLK  in  1  system pixel clock (Elbert 12 MHz)
RST_N  in  1  asynchronous active-low reset
X  in  10  pixel column from timing generator
Y  in  10  line from timing generator
BLANK  in  1  blanking from timing generator
HS_IN  in  1  horizontal sync from timing generator, active low
VS_IN  in  1  vertical sync from timing generator, active low
WE  in  1  host write valid
WADDR  in  ADDR_W  host cell address, row*COLS+col
WDATA  in  8  host colour, RGB332
WREADY  out  1  write port ready
CLR  in  1  single-cycle clear request
BUSY  out  1  clear engine active
HS  out  1  delayed horizontal sync to pin
VS  out  1  delayed vertical sync to pin
RGB  out  8  pixel colour {R[2:0],G[2:0],B[1:0]}

Behaviour:
- Reset (RST_N low, async): RGB=0, HS=1, VS=1, BUSY=0, WREADY=1, FSM=IDLE, clear counter=0. RAM contents are not reset.
- Read address is combinational from the inputs: col=X>>CELL_SHIFT, row=Y>>CELL_SHIFT, addr=row*COLS+col.
- Out-of-range handling: addr is forced to 0 and the pixel is marked blank when BLANK=1, col>=COLS or row>=ROWS.
- Pipeline, fixed latency 2 cycles for all of RGB, HS and VS:
  - Edge n: RAM registers the read data; HS_IN, VS_IN and the blank flag go into stage-1 registers.
  - Edge n+1: RGB <= blank1 ? 0 : rdata; HS <= HS1; VS <= VS1.
- Write handshake:
  - A write is accepted on an edge where WE & WREADY. WREADY = ~BUSY (registered).
  - An accepted write with WADDR >= COLS*ROWS is completed but discarded, with no RAM change.
  - The host holds WE/WADDR/WDATA until accepted.
- Clear FSM, IDLE -> CLEAR:
  - IDLE -> CLEAR on CLR=1 sampled in IDLE; BUSY=1 and WREADY=0 from the next cycle.
  - In CLEAR, the engine writes CLR_COLOR at counter address, one per cycle, counter 0..COLS*ROWS-1.
  - After the write at COLS*ROWS-1 (4799), FSM -> IDLE, counter -> 0, BUSY=0 and WREADY=1 the following cycle. BUSY is high for exactly 4800 cycles.
  - CLR while in CLEAR is ignored; it neither restarts nor extends the clear.
- Simultaneous CLR and accepted WE in IDLE: the host write is performed that edge. The clear starts next cycle and eventually overwrites it.
- Read/write collision on the same address: scan-out returns old data (read-first); no stall.
- Reset mid-clear: returns to IDLE immediately; buffer is left partially cleared; scan-out continues.
- Scan-out never stalls and never depends on BUSY.

Decomposition:
- Package vga_fb_pkg holds:
  - FB_COLS=80, FB_ROWS=60, FB_DEPTH=4800, FB_ADDR_W=13, CELL_SHIFT=3.
  - RGB332 field positions.
  - The 2-cycle SCAN_LATENCY constant, also used by the bench.
- One sub-module, vga_fb_ram:
  - Simple dual-port RAM, FB_DEPTH x 8, one sync write port and one sync read port, read-first.
  - Written so it infers block RAM.
- Clear FSM, address arithmetic and the delay pipeline live in vga_fb_scan.

Test Plan:
- Reset and sync delay: drive RST_N low then high, then HS_IN low for 3 cycles -> RGB=0, HS=VS=1 during reset; HS low exactly 3 cycles starting 2 cycles later.
- Single write and readback: write WADDR=81 (row1,col1), WDATA=8'hE3; scan X=8..15, Y=8..15 unblanked -> RGB=8'hE3 at latency 2; X=16 -> neighbour cell value.
- Blank and out-of-range: BLANK=1, or Y=480, or X=640 with nonzero RAM -> RGB=0 two cycles later; no out-of-bounds RAM access.
- Clear sequence: pulse CLR -> BUSY high for exactly 4800 cycles and WREADY low throughout; every cell then reads 8'h00. CLR pulsed again mid-clear -> no length change.
- Write contention: WE held during clear with WADDR=5, WDATA=8'h1C -> accepted on the first cycle after BUSY falls; cell 5 = 8'h1C. CLR plus WE in the same IDLE cycle -> cell ends as CLR_COLOR.
- Reset mid-clear and bad address: assert RST_N low at clear count 2000 -> BUSY=0 at once; cells 0..1999 cleared, others unchanged. Write WADDR=4800 -> handshake completes, RAM unchanged.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared constants for the framebuffer scan-out stage: geometry, RGB332 layout,
// scan pipeline latency and the clear-engine state encoding.
package vga_fb_pkg;

    localparam int FB_COLS      = 80;
    localparam int FB_ROWS      = 60;
    localparam int FB_DEPTH     = FB_COLS * FB_ROWS;
    localparam int FB_ADDR_W    = 13;
    localparam int CELL_SHIFT   = 3;
    localparam int SCAN_LATENCY = 2;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_t;

    function automatic logic [7:0] rgb332(input logic [2:0] r, input logic [2:0] g,
                                          input logic [1:0] b);
        logic [7:0] p;
        p              = '0;
        p[R_MSB:R_LSB] = r;
        p[G_MSB:G_LSB] = g;
        p[B_MSB:B_LSB] = b;
        return p;
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port framebuffer RAM: one synchronous write port, one synchronous
// read port, read-first on a same-address collision. No reset so it maps to block RAM.
module vga_fb_ram #(
    parameter int DEPTH = 4800,
    parameter int AW    = 13,
    parameter int DW    = 8
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_fb_scan.sv
// Framebuffer scan-out: maps timing-generator x/y to an 8x8-cell framebuffer,
// delays sync to match RAM latency, and hosts the write port and clear engine.
//
// state    | meaning
// ST_IDLE  | host writes accepted, CLR starts a clear
// ST_CLEAR | engine fills one cell per cycle with CLR_COLOR, host port stalled
module vga_fb_scan #(
    parameter int         COLS       = vga_fb_pkg::FB_COLS,
    parameter int         ROWS       = vga_fb_pkg::FB_ROWS,
    parameter int         CELL_SHIFT = vga_fb_pkg::CELL_SHIFT,
    parameter logic [7:0] CLR_COLOR  = 8'h00,
    parameter int         ADDR_W     = vga_fb_pkg::FB_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [9:0]        X,
    input  logic [9:0]        Y,
    input  logic              BLANK,
    input  logic              HS_IN,
    input  logic              VS_IN,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [7:0]        WDATA,
    output logic              WREADY,
    input  logic              CLR,
    output logic              BUSY,
    output logic              HS,
    output logic              VS,
    output logic [7:0]        RGB
);

    import vga_fb_pkg::*;

    localparam int                DEPTH   = COLS * ROWS;
    localparam logic [9:0]        COLS_W  = 10'(COLS);
    localparam logic [9:0]        ROWS_W  = 10'(ROWS);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    clr_state_t        state;
    logic [ADDR_W-1:0] clr_cnt;

    logic [9:0]        col;
    logic [9:0]        row;
    logic              pix_on;
    logic [ADDR_W-1:0] raddr;
    logic [7:0]        rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    logic              blank1;
    logic              hs1;
    logic              vs1;

    assign col    = X >> CELL_SHIFT;
    assign row    = Y >> CELL_SHIFT;
    assign pix_on = !BLANK && (col < COLS_W) && (row < ROWS_W);
    // Off-screen pixels read cell 0 so the RAM never sees an out-of-range address.
    assign raddr  = pix_on ? (ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col)) : '0;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = WADDR;
        ram_wdata = WDATA;
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = CLR_COLOR;
        end else if (WE && WREADY && (WADDR < DEPTH_A)) begin
            ram_we = 1'b1;
        end
    end

    vga_fb_ram #(
        .DEPTH (DEPTH),
        .AW    (ADDR_W),
        .DW    (8)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
            BUSY    <= 1'b0;
            WREADY  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CLR) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        BUSY    <= 1'b1;
                        WREADY  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == LAST_A) begin
                        state   <= ST_IDLE;
                        clr_cnt <= '0;
                        BUSY    <= 1'b0;
                        WREADY  <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage 1 runs alongside the RAM read; stage 2 drives the pins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blank1 <= 1'b1;
            hs1    <= 1'b1;
            vs1    <= 1'b1;
            RGB    <= 8'h00;
            HS     <= 1'b1;
            VS     <= 1'b1;
        end else begin
            blank1 <= !pix_on;
            hs1    <= HS_IN;
            vs1    <= VS_IN;
            RGB    <= blank1 ? 8'h00 : rdata;
            HS     <= hs1;
            VS     <= vs1;
        end
    end

endmodule
